// File: rtl/pulse_voice_bank_pkg.sv
// Shared types and configuration for the pulse voice bank.
// Build option: PULSE_HARD_SYNC_EN enables voice-0 hard sync in the datapath.
package pulse_voice_bank_pkg;

    localparam int AUDIO_BIT_WIDTH = 16;

    typedef enum logic {
        FRONT = 1'b0,
        BACK  = 1'b1
    } oscillator_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } pulse_fsm_t;

endpackage

// File: rtl/pulse_voice_eval.sv
// Single-voice pulse evaluate/advance datapath, shared by all voices in turn.
// Build option: PULSE_HARD_SYNC_EN adds the sync input and wrap carry output.
module pulse_voice_eval
    import pulse_voice_bank_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int DUTY_WIDTH  = 8,
    parameter int AUDIO_WIDTH = AUDIO_BIT_WIDTH
) (
    input  logic                          en,
    input  logic [PHASE_WIDTH-1:0]        phase,
    input  logic [PHASE_WIDTH-1:0]        phase_inc,
    input  logic [DUTY_WIDTH-1:0]         duty,
`ifdef PULSE_HARD_SYNC_EN
    input  logic                          sync,
    output logic                          carry,
`endif
    output oscillator_state_t             state,
    output logic signed [AUDIO_WIDTH-1:0] contrib,
    output logic [PHASE_WIDTH-1:0]        next_phase
);

    localparam logic signed [AUDIO_WIDTH-1:0] AMP = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};

    assign state   = (phase[PHASE_WIDTH-1 -: DUTY_WIDTH] < duty) ? FRONT : BACK;
    assign contrib = !en ? '0 : ((state == FRONT) ? AMP : -AMP);

`ifdef PULSE_HARD_SYNC_EN
    logic [PHASE_WIDTH:0] sum;
    assign sum        = {1'b0, phase} + {1'b0, phase_inc};
    assign carry      = en & sum[PHASE_WIDTH];
    assign next_phase = (!en || sync) ? '0 : sum[PHASE_WIDTH-1:0];
`else
    logic [PHASE_WIDTH-1:0] sum;
    assign sum        = phase + phase_inc;
    assign next_phase = en ? sum : '0;
`endif

endmodule

// File: rtl/pulse_voice_bank.sv
// Multi-voice pulse oscillator bank: one shared voice datapath, one mixed sample per tick.
// Build option: PULSE_HARD_SYNC_EN resets voices 1.. when voice 0 wraps within a sample.
module pulse_voice_bank
    import pulse_voice_bank_pkg::*;
#(
    parameter int VOICES      = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int DUTY_WIDTH  = 8,
    parameter int AUDIO_WIDTH = AUDIO_BIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_tick,
    input  logic [VOICES-1:0]              voice_en,
    input  logic [VOICES*PHASE_WIDTH-1:0]  phase_inc,
    input  logic [VOICES*DUTY_WIDTH-1:0]   duty,
    output logic signed [AUDIO_WIDTH-1:0]  out_sample,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           overrun
);

    localparam int IW = $clog2(VOICES);
    localparam int AW = AUDIO_WIDTH + IW;
    localparam logic [IW-1:0] LAST = IW'(VOICES - 1);

    logic [VOICES-1:0][PHASE_WIDTH-1:0] phase;
    logic [VOICES-1:0][PHASE_WIDTH-1:0] inc_v;
    logic [VOICES-1:0][DUTY_WIDTH-1:0]  duty_v;

    pulse_fsm_t         state;
    logic [IW-1:0]      idx;
    logic signed [AW-1:0] acc;

    oscillator_state_t             v_state;
    logic signed [AUDIO_WIDTH-1:0] v_contrib;
    logic [PHASE_WIDTH-1:0]        v_next;
    logic signed [AW-1:0]          contrib_ext;
    logic signed [AW-1:0]          acc_sum;
    logic                          unused_state;

    assign inc_v  = phase_inc;
    assign duty_v = duty;

`ifdef PULSE_HARD_SYNC_EN
    logic sync_flag;
    logic v_carry;
`endif

    pulse_voice_eval #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .DUTY_WIDTH (DUTY_WIDTH),
        .AUDIO_WIDTH(AUDIO_WIDTH)
    ) u_eval (
        .en        (voice_en[idx]),
        .phase     (phase[idx]),
        .phase_inc (inc_v[idx]),
        .duty      (duty_v[idx]),
`ifdef PULSE_HARD_SYNC_EN
        .sync      (sync_flag),
        .carry     (v_carry),
`endif
        .state     (v_state),
        .contrib   (v_contrib),
        .next_phase(v_next)
    );

    // The FRONT/BACK flag is folded into the contribution; kept visible for debug.
    assign unused_state = (v_state == FRONT);

    assign contrib_ext = {{IW{v_contrib[AUDIO_WIDTH-1]}}, v_contrib};
    assign acc_sum     = acc + contrib_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            phase      <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
`ifdef PULSE_HARD_SYNC_EN
            sync_flag  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= ACCUM;
                        idx   <= '0;
                        acc   <= '0;
`ifdef PULSE_HARD_SYNC_EN
                        sync_flag <= 1'b0;
`endif
                    end
                end
                ACCUM: begin
                    phase[idx] <= v_next;
                    acc        <= acc_sum;
`ifdef PULSE_HARD_SYNC_EN
                    // Voice 0 is always first, so the flag only affects later slots.
                    if (idx == '0 && v_carry)
                        sync_flag <= 1'b1;
`endif
                    if (sample_tick)
                        overrun <= 1'b1;
                    if (idx == LAST) begin
                        state      <= HOLD;
                        out_valid  <= 1'b1;
                        out_sample <= AUDIO_WIDTH'(acc_sum >>> IW);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (sample_tick)
                        overrun <= 1'b1;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
